// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives a synchronous-read data memory, hides its
// one-cycle read latency with a single stall cycle and feeds the MEM/WB register.
module mem_stage #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int RW = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic          ex_load,
    input  logic          ex_store,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_wdata,
    input  logic [DW-1:0] ex_alu,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_wb_en,
    input  logic          flush,
    output logic          stall,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    output logic          dm_dwe,
    input  logic [DW-1:0] dm_rdata,
    output logic          wb_valid,
    output logic          wb_en,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    output logic [CW-1:0] load_cnt,
    output logic [CW-1:0] store_cnt,
    output logic          err
);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          wb_valid_q, wb_valid_d;
    logic          wb_en_q, wb_en_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [CW-1:0] load_cnt_q, load_cnt_d;
    logic [CW-1:0] store_cnt_q, store_cnt_d;
    logic          err_q, err_d;
    logic          accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rd_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            err_q       <= err_d;
        end
    end

    // A store wins when load and store are both raised; the conflict only sets err.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        wb_valid_d  = 1'b0;
        wb_en_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        err_d       = err_q;
        stall       = 1'b0;
        dm_addr     = ex_addr;
        dm_wdata    = ex_wdata;
        dm_dwe      = 1'b0;
        accept      = ex_valid && (state_q == IDLE) && !flush;

        case (state_q)
            IDLE: begin
                dm_dwe = ex_valid && ex_store && !flush;
                if (accept) begin
                    if (ex_store) begin
                        wb_valid_d  = 1'b1;
                        store_cnt_d = store_cnt_q + 1'b1;
                        if (ex_load) begin
                            err_d = 1'b1;
                        end
                    end else if (ex_load) begin
                        addr_d  = ex_addr;
                        rd_d    = ex_rd;
                        state_d = LOAD_WAIT;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_en_d    = ex_wb_en;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ex_alu;
                    end
                end
            end
            LOAD_WAIT: begin
                stall   = 1'b1;
                dm_addr = addr_q;
                state_d = IDLE;
                if (!flush) begin
                    wb_valid_d = 1'b1;
                    wb_en_d    = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = dm_rdata;
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset must kill any write strobe immediately, not at the next edge.
        if (!rst) begin
            dm_dwe = 1'b0;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_en     = wb_en_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a synchronous-read 256x16 data memory model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_load, ex_store, ex_wb_en, flush;
    logic [7:0]  ex_addr;
    logic [15:0] ex_wdata, ex_alu;
    logic [2:0]  ex_rd;
    logic        stall, dm_dwe;
    logic [7:0]  dm_addr;
    logic [15:0] dm_wdata, dm_rdata;
    logic        wb_valid, wb_en, err;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data, load_cnt, store_cnt;

    logic [15:0] mem [0:255];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_dwe) mem[dm_addr] <= dm_wdata;
        dm_rdata <= mem[dm_addr];
    end

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_alu(ex_alu),
        .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .flush(flush),
        .stall(stall), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_dwe(dm_dwe),
        .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .load_cnt(load_cnt), .store_cnt(store_cnt), .err(err)
    );

    task automatic applyStimulus(input logic v, input logic ld, input logic st,
                                 input logic [7:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] alu, input logic [2:0] rd,
                                 input logic wben, input logic fl);
        ex_valid = v;   ex_load = ld;   ex_store = st;
        ex_addr  = addr; ex_wdata = wdata; ex_alu = alu;
        ex_rd    = rd;  ex_wb_en = wben; flush = fl;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[4]  = 16'h000A;
        mem[12] = 16'h000B;
        dm_rdata = 16'h0000;
        rst = 1'b0;
        idle();
        tick();
        tick();

        // Reset: a store presented during reset must not reach memory
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h30, 16'hFFFF, 16'h0000, 3'd0, 1'b0, 1'b0);
        checkOutput("rst_dwe", 32'(dm_dwe), 32'h0);
        checkOutput("rst_stall", 32'(stall), 32'h0);
        checkOutput("rst_wbv", 32'(wb_valid), 32'h0);
        checkOutput("rst_wben", 32'(wb_en), 32'h0);
        checkOutput("rst_wbrd", 32'(wb_rd), 32'h0);
        checkOutput("rst_wbdata", 32'(wb_data), 32'h0);
        checkOutput("rst_lcnt", 32'(load_cnt), 32'h0);
        checkOutput("rst_scnt", 32'(store_cnt), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        idle();
        rst = 1'b1;
        tick();

        // Single load addr 4 -> rd 2
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd4, 16'h0000, 16'h0000, 3'd2, 1'b1, 1'b0);
        checkOutput("ld_c1_stall", 32'(stall), 32'h0);
        checkOutput("ld_c1_addr", 32'(dm_addr), 32'h4);
        checkOutput("ld_c1_dwe", 32'(dm_dwe), 32'h0);
        tick();
        idle();
        checkOutput("ld_c2_stall", 32'(stall), 32'h1);
        checkOutput("ld_c2_wbv", 32'(wb_valid), 32'h0);
        checkOutput("ld_c2_addr", 32'(dm_addr), 32'h4);
        tick();
        checkOutput("ld_c3_wbv", 32'(wb_valid), 32'h1);
        checkOutput("ld_c3_wben", 32'(wb_en), 32'h1);
        checkOutput("ld_c3_wbrd", 32'(wb_rd), 32'h2);
        checkOutput("ld_c3_data", 32'(wb_data), 32'h000A);
        checkOutput("ld_c3_lcnt", 32'(load_cnt), 32'h1);
        checkOutput("ld_c3_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("ld_c4_wbv", 32'(wb_valid), 32'h0);

        // Store 0x1234 to 0x20, then load 0x20 into rd 3
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h20, 16'h1234, 16'h0000, 3'd0, 1'b0, 1'b0);
        checkOutput("st_c1_dwe", 32'(dm_dwe), 32'h1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h20, 16'h0000, 16'h0000, 3'd3, 1'b1, 1'b0);
        checkOutput("st_c2_dwe", 32'(dm_dwe), 32'h0);
        checkOutput("st_c2_wbv", 32'(wb_valid), 32'h1);
        checkOutput("st_c2_wben", 32'(wb_en), 32'h0);
        checkOutput("st_c2_scnt", 32'(store_cnt), 32'h1);
        tick();
        idle();
        checkOutput("st_c3_stall", 32'(stall), 32'h1);
        checkOutput("st_c3_dwe", 32'(dm_dwe), 32'h0);
        tick();
        checkOutput("st_c4_wbv", 32'(wb_valid), 32'h1);
        checkOutput("st_c4_data", 32'(wb_data), 32'h1234);
        checkOutput("st_c4_wbrd", 32'(wb_rd), 32'h3);
        checkOutput("st_c4_lcnt", 32'(load_cnt), 32'h2);

        // Back-to-back loads 4 -> rd1, 12 -> rd6
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd4, 16'h0000, 16'h0000, 3'd1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd12, 16'h0000, 16'h0000, 3'd6, 1'b1, 1'b0);
        checkOutput("b2b_c2_stall", 32'(stall), 32'h1);
        checkOutput("b2b_c2_addr", 32'(dm_addr), 32'h4);
        tick();
        checkOutput("b2b_c3_stall", 32'(stall), 32'h0);
        checkOutput("b2b_c3_wbv", 32'(wb_valid), 32'h1);
        checkOutput("b2b_c3_data", 32'(wb_data), 32'h000A);
        checkOutput("b2b_c3_wbrd", 32'(wb_rd), 32'h1);
        tick();
        idle();
        checkOutput("b2b_c4_stall", 32'(stall), 32'h1);
        checkOutput("b2b_c4_wbv", 32'(wb_valid), 32'h0);
        tick();
        checkOutput("b2b_c5_wbv", 32'(wb_valid), 32'h1);
        checkOutput("b2b_c5_data", 32'(wb_data), 32'h000B);
        checkOutput("b2b_c5_wbrd", 32'(wb_rd), 32'h6);
        checkOutput("b2b_c5_lcnt", 32'(load_cnt), 32'h4);

        // Load aborted by flush in LOAD_WAIT
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd4, 16'h0000, 16'h0000, 3'd7, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1);
        checkOutput("fl_c2_stall", 32'(stall), 32'h1);
        tick();
        idle();
        checkOutput("fl_c3_wbv", 32'(wb_valid), 32'h0);
        checkOutput("fl_c3_lcnt", 32'(load_cnt), 32'h4);
        checkOutput("fl_c3_stall", 32'(stall), 32'h0);

        // Flush in IDLE drops a store
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h40, 16'hDEAD, 16'h0000, 3'd0, 1'b0, 1'b1);
        checkOutput("fli_dwe", 32'(dm_dwe), 32'h0);
        tick();
        idle();
        checkOutput("fli_wbv", 32'(wb_valid), 32'h0);
        checkOutput("fli_scnt", 32'(store_cnt), 32'h1);
        checkOutput("fli_mem", 32'(mem[8'h40]), 32'h0);

        // ALU op 0x0055 -> rd 5, then idle holds wb_data
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0055, 3'd5, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("alu_wbv", 32'(wb_valid), 32'h1);
        checkOutput("alu_wben", 32'(wb_en), 32'h1);
        checkOutput("alu_wbrd", 32'(wb_rd), 32'h5);
        checkOutput("alu_data", 32'(wb_data), 32'h0055);
        tick();
        checkOutput("hold_wbv", 32'(wb_valid), 32'h0);
        checkOutput("hold_wben", 32'(wb_en), 32'h0);
        checkOutput("hold_data", 32'(wb_data), 32'h0055);
        checkOutput("hold_wbrd", 32'(wb_rd), 32'h5);

        // Load and store together to addr 8: treated as a store, err sticks
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd8, 16'hBEEF, 16'h0000, 3'd4, 1'b1, 1'b0);
        checkOutput("both_dwe", 32'(dm_dwe), 32'h1);
        tick();
        idle();
        checkOutput("both_stall", 32'(stall), 32'h0);
        checkOutput("both_wbv", 32'(wb_valid), 32'h1);
        checkOutput("both_wben", 32'(wb_en), 32'h0);
        checkOutput("both_err", 32'(err), 32'h1);
        checkOutput("both_scnt", 32'(store_cnt), 32'h2);
        checkOutput("both_lcnt", 32'(load_cnt), 32'h4);
        checkOutput("both_mem", 32'(mem[8]), 32'hBEEF);
        tick();
        tick();
        checkOutput("err_sticky", 32'(err), 32'h1);

        // Reset asserted in the middle of LOAD_WAIT
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd4, 16'h0000, 16'h0000, 3'd2, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h50, 16'h7777, 16'h0000, 3'd0, 1'b0, 1'b0);
        checkOutput("mrst_pre_stall", 32'(stall), 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("mrst_stall", 32'(stall), 32'h0);
        checkOutput("mrst_dwe", 32'(dm_dwe), 32'h0);
        checkOutput("mrst_wbv", 32'(wb_valid), 32'h0);
        checkOutput("mrst_data", 32'(wb_data), 32'h0);
        checkOutput("mrst_lcnt", 32'(load_cnt), 32'h0);
        checkOutput("mrst_scnt", 32'(store_cnt), 32'h0);
        checkOutput("mrst_err", 32'(err), 32'h0);
        idle();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("post_rst_wbv", 32'(wb_valid), 32'h0);
        checkOutput("post_rst_lcnt", 32'(load_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the EX stage and the synchronous-read data memory (8-bit address, 16-bit data, registered read data).
- Drives the memory's address, write-data and write-enable, and absorbs its one-cycle read latency with a single-cycle stall.
- Feeds the MEM/WB register: destination register, write-enable and result to the writeback stage.
- Keeps retired load/store counters.

Parameters:
- AW, 8, data-memory address width
- DW, 16, data width
- RW, 3, register-file index width
- CW, 16, retire-counter width

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- ex_valid  input  1  EX presents an instruction this cycle
- ex_load  input  1  instruction is a load
- ex_store  input  1  instruction is a store
- ex_addr  input  AW  effective address
- ex_wdata  input  DW  store data
- ex_alu  input  DW  ALU result for non-memory instructions
- ex_rd  input  RW  destination register
- ex_wb_en  input  1  instruction writes the register file
- flush  input  1  squash the instruction in this stage
- stall  output  1  EX must hold its current instruction
- dm_addr  output  AW  data-memory address
- dm_wdata  output  DW  data-memory write data
- dm_dwe  output  1  data-memory write enable
- dm_rdata  input  DW  data-memory read data (registered in memory)
- wb_valid  output  1  MEM/WB slot holds a retired instruction
- wb_en  output  1  register write enable
- wb_rd  output  RW  destination register
- wb_data  output  DW  writeback value
- load_cnt  output  CW  loads retired
- store_cnt  output  CW  stores retired
- err  output  1  sticky: load and store asserted together

Behaviour:
- States: IDLE, LOAD_WAIT.
- Reset (async, rst=0):
  - state=IDLE; wb_valid=0, wb_en=0, wb_rd=0, wb_data=0; counters=0; err=0.
  - dm_dwe forced 0 combinationally while rst=0.
- Accept: an instruction is accepted in a cycle when ex_valid=1, state=IDLE and flush=0.
- IDLE, combinational outputs:
  - dm_addr=ex_addr; dm_wdata=ex_wdata.
  - dm_dwe=ex_valid&ex_store&!flush.
  - stall=0.
- Store accepted in cycle N:
  - Write commits at the edge ending N.
  - Next cycle: wb_valid=1, wb_en=0, store_cnt+1.
- Non-memory instruction accepted in N:
  - Next cycle: wb_valid=1, wb_en=ex_wb_en, wb_rd=ex_rd, wb_data=ex_alu.
- Load accepted in N:
  - Latch addr/rd into hold registers; go to LOAD_WAIT.
  - wb_valid=0 in N+1.
- LOAD_WAIT (cycle N+1):
  - stall=1; dm_addr=held address; dm_dwe=0.
  - dm_rdata holds mem[addr] captured at the edge ending N.
  - At the edge ending N+1: wb_valid=1, wb_en=1, wb_rd=held rd, wb_data=dm_rdata, load_cnt+1; return to IDLE.
  - Load-to-use latency is 2 cycles from accept to wb_valid.
- Load immediately after a store to the same address: returns the new data; no hazard logic needed.
- No instruction accepted (ex_valid=0 or flush), IDLE: next cycle wb_valid=0, wb_en=0; wb_rd and wb_data hold.
- flush:
  - In IDLE, the current instruction is dropped: dm_dwe=0, no counter update.
  - In LOAD_WAIT: the load is aborted, state returns to IDLE, wb_valid=0 next cycle, load_cnt unchanged, stall still 1 that cycle.
- ex_load=ex_store=1 with ex_valid: treated as a store only; err set and held until reset.
- ex_load or ex_store with ex_valid=0: ignored.
- Counters: increment by 1, wrap from 2^CW-1 to 0.
- Reset mid-LOAD_WAIT: immediate IDLE, no writeback; an in-flight dm_dwe drops immediately.

Test Plan:
- Reset, with memory preloaded mem[4]=0x000A -> all outputs 0, stall=0, dm_dwe=0.
- Load addr 4, rd=2 in cycle 1 -> stall=1 in cycle 2; wb_valid=1, wb_rd=2, wb_data=0x000A in cycle 3; load_cnt=1.
- Store 0x1234 to addr 0x20 in cycle 1, load 0x20 in cycle 2 -> dm_dwe=1 only in cycle 1; wb_data=0x1234 in cycle 4; store_cnt=1, load_cnt=1.
- Back-to-back loads addr 4 then 12, mem[12]=0x000B -> second load held by stall; wb_data 0x000A then 0x000B on consecutive wb_valid pulses, 2 cycles apart.
- Load then flush during LOAD_WAIT -> wb_valid stays 0, load_cnt=0, state IDLE next cycle. Separately, ALU op ex_alu=0x0055, rd=5 -> next cycle wb_valid=1, wb_data=0x0055.
- ex_load=ex_store=1 to addr 8 -> memory written, no load writeback, err=1 until rst pulsed low; rst asserted during LOAD_WAIT -> outputs 0 immediately.
